// File: rtl/vga_fade_stage.sv
// Post-mux video stage: frame-synchronous fade-out / hold / fade-in on request,
// with hsync/vsync/blankN realigned to the one-clock-delayed RGB path.

module vga_fade_chan #(
  parameter int LOG2_STEPS = 3
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  vis_i,
  input  logic [LOG2_STEPS:0]   lvl_i,
  input  logic [7:0]            pix_i,
  output logic [7:0]            pix_o
);
  logic [8+LOG2_STEPS:0] prod;
  logic [7:0]            pix_d, pix_q;

  // Widen both operands so the product never overflows; L<=MAX keeps the result in 8 bits.
  assign prod  = {{(LOG2_STEPS+1){1'b0}}, pix_i} * {8'd0, lvl_i};
  assign pix_d = vis_i ? 8'(prod >> LOG2_STEPS) : 8'd0;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) pix_q <= '0;
    else         pix_q <= pix_d;

  assign pix_o = pix_q;
endmodule

module vga_fade_stage #(
  parameter int LOG2_STEPS      = 3,
  parameter int FRAMES_PER_STEP = 4,
  parameter int HOLD_FRAMES     = 30,
  parameter int SYNC_DELAY      = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       fadeTrigger,
  input  logic [7:0] redIn,
  input  logic [7:0] greenIn,
  input  logic [7:0] blueIn,
  input  logic       hsyncIn,
  input  logic       vsyncIn,
  input  logic       blankNIn,
  output logic [7:0] redOut,
  output logic [7:0] greenOut,
  output logic [7:0] blueOut,
  output logic       hsyncOut,
  output logic       vsyncOut,
  output logic       blankNOut,
  output logic       fadeBusy,
  output logic       holdActive
);
  localparam logic [LOG2_STEPS:0] LMAX = {1'b1, {LOG2_STEPS{1'b0}}};
  localparam logic [7:0] FPS_LAST  = 8'(FRAMES_PER_STEP - 1);
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, FADE_OUT, HOLD, FADE_IN} state_t;

  state_t                state_q, state_d;
  logic [LOG2_STEPS:0]   lvl_q, lvl_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            hold_q, hold_d;
  logic [SYNC_DELAY-1:0] hs_q, vs_q, blk_q;

  // Sync pipelines; blank tap one stage early lines up with the mux-registered RGB.
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      hs_q  <= '1;
      vs_q  <= '1;
      blk_q <= '0;
    end else begin
      hs_q  <= {hs_q[SYNC_DELAY-2:0],  hsyncIn};
      vs_q  <= {vs_q[SYNC_DELAY-2:0],  vsyncIn};
      blk_q <= {blk_q[SYNC_DELAY-2:0], blankNIn};
    end

  assign hsyncOut  = hs_q[SYNC_DELAY-1];
  assign vsyncOut  = vs_q[SYNC_DELAY-1];
  assign blankNOut = blk_q[SYNC_DELAY-1];

  logic [2:0][7:0] pix_in, pix_out;
  assign pix_in = {redIn, greenIn, blueIn};

  for (genvar i = 0; i < 3; i++) begin : g_chan
    vga_fade_chan #(.LOG2_STEPS(LOG2_STEPS)) u_chan (
      .clk   (clk),
      .resetN(resetN),
      .vis_i (blk_q[SYNC_DELAY-2]),
      .lvl_i (lvl_q),
      .pix_i (pix_in[i]),
      .pix_o (pix_out[i])
    );
  end

  assign {redOut, greenOut, blueOut} = pix_out;

  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      state_q <= IDLE;
      lvl_q   <= LMAX;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        lvl_d = LMAX;
        if (fadeTrigger) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end
      end
      FADE_OUT: begin
        if (startOfFrame) begin
          if (cnt_q == FPS_LAST) begin
            cnt_d = '0;
            lvl_d = (lvl_q == '0) ? '0 : lvl_q - 1'b1;
            if (lvl_q <= 1) begin
              state_d = HOLD;
              hold_d  = '0;
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      HOLD: begin
        lvl_d = '0;
        if (startOfFrame) begin
          if (hold_q == HOLD_LAST) begin
            state_d = FADE_IN;
            cnt_d   = '0;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      FADE_IN: begin
        // A new request reverses the fade from wherever the level is now.
        if (fadeTrigger) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end else if (startOfFrame) begin
          if (cnt_q == FPS_LAST) begin
            cnt_d = '0;
            lvl_d = (lvl_q == LMAX) ? LMAX : lvl_q + 1'b1;
            if (lvl_q >= LMAX - 1'b1) state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign fadeBusy   = (state_q != IDLE);
  assign holdActive = (state_q == HOLD);
endmodule

// File: tb/tb_vga_fade_stage.sv
// Self-checking bench for vga_fade_stage: directed scenarios plus a randomized
// full fade cycle checked against a frame-count model of the brightness level.

module tb_vga_fade_stage;
  logic       clk = 0;
  logic       resetN = 0;
  logic       startOfFrame = 0, fadeTrigger = 0;
  logic [7:0] redIn = 0, greenIn = 0, blueIn = 0;
  logic       hsyncIn = 1, vsyncIn = 1, blankNIn = 0;
  logic [7:0] redOut, greenOut, blueOut;
  logic       hsyncOut, vsyncOut, blankNOut, fadeBusy, holdActive;

  int tests = 0, fails = 0;

  vga_fade_stage dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fadeTrigger(fadeTrigger),
    .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
    .hsyncIn(hsyncIn), .vsyncIn(vsyncIn), .blankNIn(blankNIn),
    .redOut(redOut), .greenOut(greenOut), .blueOut(blueOut),
    .hsyncOut(hsyncOut), .vsyncOut(vsyncOut), .blankNOut(blankNOut),
    .fadeBusy(fadeBusy), .holdActive(holdActive)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sofs(input int n);
    for (int i = 0; i < n; i++) begin
      startOfFrame = 1; tick();
      startOfFrame = 0; tick();
    end
  endtask

  // Present a full-scale red pixel long enough for the blank pipeline to settle.
  task automatic probe(output logic [7:0] r);
    blankNIn = 1; redIn = 8'hFF;
    tick(); tick();
    r = redOut;
  endtask

  // Brightness level after n counted SOF pulses since a fade request.
  function automatic int lvl_of(input int n);
    if (n < 32) return 8 - n / 4;
    if (n < 62) return 0;
    if (n < 94) return (n - 62) / 4;
    return 8;
  endfunction

  task automatic test_reset();
    resetN = 0; redIn = 8'hFF; hsyncIn = 0; vsyncIn = 0; blankNIn = 1;
    #1;
    tests++; if ({redOut, greenOut, blueOut} !== 24'h0) begin fails++; $display("FAIL reset_rgb got %h want 000000", {redOut, greenOut, blueOut}); end
    tick(); tick();
    tests++; if (redOut !== 8'h00) begin fails++; $display("FAIL reset_red got %h want 00", redOut); end
    tests++; if ({hsyncOut, vsyncOut, blankNOut} !== 3'b110) begin fails++; $display("FAIL reset_sync got %b want 110", {hsyncOut, vsyncOut, blankNOut}); end
    tests++; if ({fadeBusy, holdActive} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b want 00", {fadeBusy, holdActive}); end
    hsyncIn = 1; vsyncIn = 1;
    resetN = 1; tick(); tick();
  endtask

  task automatic test_passthrough();
    blankNIn = 1; tick();
    redIn = 8'hA5; greenIn = 8'h3C; blueIn = 8'hC0; tick();
    tests++; if ({redOut, greenOut, blueOut} !== 24'hA53CC0) begin fails++; $display("FAIL passthrough got %h want a53cc0", {redOut, greenOut, blueOut}); end
    hsyncIn = 0; tick(); hsyncIn = 1;
    tests++; if (hsyncOut !== 1'b1) begin fails++; $display("FAIL hsync_d1 got %b want 1", hsyncOut); end
    tick();
    tests++; if (hsyncOut !== 1'b0) begin fails++; $display("FAIL hsync_d2 got %b want 0", hsyncOut); end
    tick();
    tests++; if (hsyncOut !== 1'b1) begin fails++; $display("FAIL hsync_d3 got %b want 1", hsyncOut); end
  endtask

  task automatic test_blank();
    logic [7:0] r;
    probe(r);
    blankNIn = 0; tick();
    tests++; if (redOut !== 8'hFF || blankNOut !== 1'b1) begin fails++; $display("FAIL blank_pre got %h/%b want ff/1", redOut, blankNOut); end
    blankNIn = 1; tick();
    tests++; if (redOut !== 8'h00 || blankNOut !== 1'b0) begin fails++; $display("FAIL blank_mid got %h/%b want 00/0", redOut, blankNOut); end
    tick();
    tests++; if (redOut !== 8'hFF || blankNOut !== 1'b1) begin fails++; $display("FAIL blank_post got %h/%b want ff/1", redOut, blankNOut); end
  endtask

  task automatic test_fade_cycle();
    logic [7:0] r, g, b;
    int n, lb, ok_rgb;
    blankNIn = 1; tick();
    fadeTrigger = 1; tick(); fadeTrigger = 0;
    tests++; if (fadeBusy !== 1'b1) begin fails++; $display("FAIL fade_start busy got %b want 1", fadeBusy); end
    n = 0;
    for (int f = 0; f < 95; f++) begin
      for (int c = 0; c < 4; c++) begin
        r = (c == 0 && (n == 4 || n == 94)) ? 8'hFF : 8'($urandom);
        g = 8'($urandom); b = 8'($urandom);
        redIn = r; greenIn = g; blueIn = b;
        lb = lvl_of(n);
        startOfFrame = (c == 3 && f < 94);
        tick();
        startOfFrame = 0;
        if (c == 3 && f < 94) n++;
        ok_rgb = (redOut == 8'((int'(r) * lb) >> 3)) && (greenOut == 8'((int'(g) * lb) >> 3))
              && (blueOut == 8'((int'(b) * lb) >> 3));
        tests++; if (ok_rgb != 1) begin fails++; $display("FAIL fade_rgb n=%0d L=%0d got %h%h%h in %h%h%h", n, lb, redOut, greenOut, blueOut, r, g, b); end
        tests++; if (holdActive !== (n >= 32 && n < 62)) begin fails++; $display("FAIL fade_hold n=%0d got %b", n, holdActive); end
        tests++; if (fadeBusy !== (n < 94)) begin fails++; $display("FAIL fade_busy n=%0d got %b", n, fadeBusy); end
      end
    end
  endtask

  task automatic test_races();
    logic [7:0] r;
    fadeTrigger = 1; startOfFrame = 1; tick();
    fadeTrigger = 0; startOfFrame = 0; tick();
    tests++; if (fadeBusy !== 1'b1) begin fails++; $display("FAIL race_trig_sof busy got %b want 1", fadeBusy); end
    sofs(3); probe(r);
    tests++; if (r !== 8'hFF) begin fails++; $display("FAIL race_3sof got %h want ff", r); end
    sofs(1); probe(r);
    tests++; if (r !== 8'hDF) begin fails++; $display("FAIL race_4sof got %h want df", r); end
    sofs(28);
    tests++; if (holdActive !== 1'b1) begin fails++; $display("FAIL race_hold got %b want 1", holdActive); end
    fadeTrigger = 1; tick(); fadeTrigger = 0;
    sofs(29);
    tests++; if (holdActive !== 1'b1) begin fails++; $display("FAIL race_hold_trig got %b want 1", holdActive); end
    sofs(1);
    tests++; if ({fadeBusy, holdActive} !== 2'b10) begin fails++; $display("FAIL race_fade_in got %b want 10", {fadeBusy, holdActive}); end
    sofs(16); probe(r);
    tests++; if (r !== 8'h7F) begin fails++; $display("FAIL race_L4 got %h want 7f", r); end
    fadeTrigger = 1; tick(); fadeTrigger = 0;
    sofs(3); probe(r);
    tests++; if (r !== 8'h7F) begin fails++; $display("FAIL race_rev3 got %h want 7f", r); end
    sofs(1); probe(r);
    tests++; if (r !== 8'h5F) begin fails++; $display("FAIL race_rev4 got %h want 5f", r); end
  endtask

  task automatic test_reset_mid_fade();
    logic [7:0] r;
    sofs(4); probe(r);
    tests++; if (r !== 8'h3F) begin fails++; $display("FAIL mid_L2 got %h want 3f", r); end
    resetN = 0; #1;
    tests++; if ({fadeBusy, redOut} !== 9'h000) begin fails++; $display("FAIL mid_reset got %b/%h want 0/00", fadeBusy, redOut); end
    tick(); resetN = 1;
    probe(r);
    tests++; if (r !== 8'hFF || fadeBusy !== 1'b0) begin fails++; $display("FAIL mid_after got %h/%b want ff/0", r, fadeBusy); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_blank();
    test_fade_cycle();
    test_races();
    test_reset_mid_fade();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
